// File: rtl/tlul_reg_responder.sv
// TL-UL device-side responder: turns one TL-UL request into a single-cycle
// register-bus strobe and returns AccessAck/AccessAckData, one transaction at a time.
package tlul_pkg;
  localparam int TL_AW = 32;
  localparam int TL_DW = 32;

  localparam logic [2:0] PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] GET              = 3'd4;
  localparam logic [2:0] ACCESS_ACK       = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA  = 3'd1;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [1:0]        a_size;
    logic [7:0]        a_source;
    logic [TL_AW-1:0]  a_address;
    logic [3:0]        a_mask;
    logic [TL_DW-1:0]  a_data;
    logic [15:0]       a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [1:0]        d_size;
    logic [7:0]        d_source;
    logic [0:0]        d_sink;
    logic [TL_DW-1:0]  d_data;
    logic [15:0]       d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

module tlul_reg_responder
  import tlul_pkg::*;
#(
  parameter int               RegAw    = 8,
  parameter int               RegDw    = 32,
  parameter logic [RegDw-1:0] ErrRdata = 32'hFFFF_FFFF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  tl_h2d_t            tl_i,
  output tl_d2h_t            tl_o,
  output logic               re_o,
  output logic               we_o,
  output logic [RegAw-1:0]   addr_o,
  output logic [RegDw-1:0]   wdata_o,
  output logic [RegDw/8-1:0] be_o,
  input  logic [RegDw-1:0]   rdata_i,
  input  logic               error_i
);

  if (RegDw != TL_DW) begin : g_bad_dw
    $error("RegDw must equal TL_DW");
  end
  if (RegAw < 2 || RegAw > TL_AW) begin : g_bad_aw
    $error("RegAw must lie in [2, TL_AW]");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t             state;
  logic               is_get;
  logic               err_req;
  logic               rsp_valid;
  logic [2:0]         rsp_opcode;
  logic [1:0]         rsp_size;
  logic [7:0]         rsp_source;
  logic [RegDw-1:0]   rsp_data;
  logic               rsp_error;

  // Address bits above RegAw are decoded upstream; param and user carry nothing here.
  logic unused_bits;
  assign unused_bits = ^{tl_i.a_param, tl_i.a_user, tl_i.a_address[TL_AW-1:RegAw]};

  // Protocol checks on the incoming A-channel beat.
  always_comb begin
    err_req = 1'b0;
    if (tl_i.a_opcode != GET && tl_i.a_opcode != PUT_FULL_DATA &&
        tl_i.a_opcode != PUT_PARTIAL_DATA) begin
      err_req = 1'b1;
    end else if (tl_i.a_address[1:0] != 2'b00 || tl_i.a_size > 2'd2) begin
      err_req = 1'b1;
    end else if (tl_i.a_opcode == PUT_FULL_DATA && tl_i.a_mask != 4'hF) begin
      err_req = 1'b1;
    end else begin
      err_req = 1'b0;
    end
  end

  // Transaction FSM with registered strobes and response fields.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      is_get     <= 1'b0;
      re_o       <= 1'b0;
      we_o       <= 1'b0;
      addr_o     <= '0;
      wdata_o    <= '0;
      be_o       <= '0;
      rsp_valid  <= 1'b0;
      rsp_opcode <= 3'd0;
      rsp_size   <= 2'd0;
      rsp_source <= 8'd0;
      rsp_data   <= '0;
      rsp_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tl_i.a_valid) begin
            is_get     <= (tl_i.a_opcode == GET);
            addr_o     <= {tl_i.a_address[RegAw-1:2], 2'b00};
            wdata_o    <= tl_i.a_data;
            be_o       <= tl_i.a_mask;
            rsp_size   <= tl_i.a_size;
            rsp_source <= tl_i.a_source;
            if (err_req) begin
              // Errored requests skip the backend entirely.
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_error  <= 1'b1;
              rsp_opcode <= (tl_i.a_opcode == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;
              rsp_data   <= (tl_i.a_opcode == GET) ? ErrRdata : '0;
            end else begin
              state <= ACCESS;
              re_o  <= (tl_i.a_opcode == GET);
              we_o  <= (tl_i.a_opcode != GET);
            end
          end
        end
        ACCESS: begin
          state      <= RESP;
          re_o       <= 1'b0;
          we_o       <= 1'b0;
          rsp_valid  <= 1'b1;
          rsp_error  <= error_i;
          rsp_opcode <= is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
          rsp_data   <= is_get ? (error_i ? ErrRdata : rdata_i) : '0;
        end
        RESP: begin
          if (tl_i.d_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          re_o  <= 1'b0;
          we_o  <= 1'b0;
        end
      endcase
    end
  end

  // D-channel assembly; a_ready follows the state register only.
  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = rsp_valid;
    tl_o.d_opcode = rsp_opcode;
    tl_o.d_size   = rsp_size;
    tl_o.d_source = rsp_source;
    tl_o.d_data   = rsp_data;
    tl_o.d_error  = rsp_error;
    tl_o.a_ready  = (state == IDLE);
  end

endmodule

// File: tb/tb_tlul_reg_responder.sv
// Directed-vector bench for tlul_reg_responder with hand-computed expectations.
module tb_tlul_reg_responder;
  import tlul_pkg::*;

  logic        clk;
  logic        rst_i;
  tl_h2d_t     tl_i;
  tl_d2h_t     tl_o;
  logic        re_o, we_o;
  logic [7:0]  addr_o;
  logic [31:0] wdata_o;
  logic [3:0]  be_o;
  logic [31:0] rdata_i;
  logic        error_i;

  int n_vec = 0;
  int n_err = 0;

  tlul_reg_responder dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .tl_i    (tl_i),
    .tl_o    (tl_o),
    .re_o    (re_o),
    .we_o    (we_o),
    .addr_o  (addr_o),
    .wdata_o (wdata_o),
    .be_o    (be_o),
    .rdata_i (rdata_i),
    .error_i (error_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                         input logic [7:0] src, input logic [3:0] mask, input logic [31:0] data);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = op;
    tl_i.a_param   = 3'd0;
    tl_i.a_size    = size;
    tl_i.a_source  = src;
    tl_i.a_address = addr;
    tl_i.a_mask    = mask;
    tl_i.a_data    = data;
  endtask

  // strobe: 0 none (errored request), 1 re_o, 2 we_o
  task automatic do_txn(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [1:0] size, input logic [7:0] src, input logic [3:0] mask,
                        input logic [31:0] data, input int strobe, input logic exp_err,
                        input logic [2:0] exp_dop, input logic [7:0] exp_addr,
                        input logic [31:0] exp_ddata);
    @(negedge clk);
    check({tag, "_a_ready"}, 64'(tl_o.a_ready), 64'd1);
    drive_a(op, addr, size, src, mask, data);
    tl_i.d_ready = 1'b1;
    @(negedge clk);
    tl_i.a_valid = 1'b0;
    check({tag, "_re"}, 64'(re_o), 64'(strobe == 1));
    check({tag, "_we"}, 64'(we_o), 64'(strobe == 2));
    if (strobe != 0) begin
      check({tag, "_addr"}, 64'(addr_o), 64'(exp_addr));
      check({tag, "_dvalid_early"}, 64'(tl_o.d_valid), 64'd0);
      if (strobe == 2) begin
        check({tag, "_wdata"}, 64'(wdata_o), 64'(data));
        check({tag, "_be"}, 64'(be_o), 64'(mask));
      end
      @(negedge clk);
      check({tag, "_strobe_off"}, 64'({re_o, we_o}), 64'd0);
    end
    check({tag, "_dvalid"}, 64'(tl_o.d_valid), 64'd1);
    check({tag, "_dopcode"}, 64'(tl_o.d_opcode), 64'(exp_dop));
    check({tag, "_ddata"}, 64'(tl_o.d_data), 64'(exp_ddata));
    check({tag, "_derror"}, 64'(tl_o.d_error), 64'(exp_err));
    check({tag, "_dsource"}, 64'(tl_o.d_source), 64'(src));
    check({tag, "_dsize"}, 64'(tl_o.d_size), 64'(size));
    @(negedge clk);
    check({tag, "_dvalid_fall"}, 64'(tl_o.d_valid), 64'd0);
    check({tag, "_idle"}, 64'(tl_o.a_ready), 64'd1);
  endtask

  initial begin
    rst_i   = 1'b1;
    tl_i    = '0;
    tl_i.d_ready = 1'b1;
    rdata_i = 32'd0;
    error_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_a_ready", 64'(tl_o.a_ready), 64'd1);
    check("rst_d_fields", 64'(tl_o.d_valid) | 64'(tl_o.d_data) | 64'(tl_o.d_opcode) |
          64'(tl_o.d_error) | 64'(tl_o.d_source), 64'd0);
    check("rst_bus", 64'({re_o, we_o, addr_o, be_o}) | 64'(wdata_o), 64'd0);
    rst_i = 1'b0;

    rdata_i = 32'hDEAD_BEEF;
    do_txn("get", GET, 32'h10, 2'd2, 8'h05, 4'hF, 32'h0, 1, 1'b0, ACCESS_ACK_DATA, 8'h10, 32'hDEAD_BEEF);
    do_txn("putfull", PUT_FULL_DATA, 32'h24, 2'd2, 8'h01, 4'hF, 32'h1234_5678, 2, 1'b0, ACCESS_ACK, 8'h24, 32'h0);
    do_txn("putpart", PUT_PARTIAL_DATA, 32'h30, 2'd1, 8'h02, 4'h3, 32'hAABB_CCDD, 2, 1'b0, ACCESS_ACK, 8'h30, 32'h0);
    do_txn("putfull_badmask", PUT_FULL_DATA, 32'h34, 2'd2, 8'h03, 4'h3, 32'h1, 0, 1'b1, ACCESS_ACK, 8'h0, 32'h0);
    do_txn("get_misalign", GET, 32'h13, 2'd2, 8'h04, 4'hF, 32'h0, 0, 1'b1, ACCESS_ACK_DATA, 8'h0, 32'hFFFF_FFFF);
    do_txn("bad_opcode", 3'h2, 32'h20, 2'd2, 8'h06, 4'hF, 32'h0, 0, 1'b1, ACCESS_ACK, 8'h0, 32'h0);
    do_txn("get_size3", GET, 32'h20, 2'd3, 8'h07, 4'hF, 32'h0, 0, 1'b1, ACCESS_ACK_DATA, 8'h0, 32'hFFFF_FFFF);
    rdata_i = 32'h0BAD_F00D;
    do_txn("get_highaddr", GET, 32'h1234_5640, 2'd2, 8'h08, 4'hF, 32'h0, 1, 1'b0, ACCESS_ACK_DATA, 8'h40, 32'h0BAD_F00D);
    error_i = 1'b1;
    do_txn("put_backerr", PUT_FULL_DATA, 32'h60, 2'd2, 8'h0A, 4'hF, 32'h77, 2, 1'b1, ACCESS_ACK, 8'h60, 32'h0);
    do_txn("get_backerr", GET, 32'h64, 2'd2, 8'h0B, 4'hF, 32'h0, 1, 1'b1, ACCESS_ACK_DATA, 8'h64, 32'hFFFF_FFFF);
    error_i = 1'b0;

    // Backpressure with a second request queued behind the response.
    rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    drive_a(GET, 32'h44, 2'd2, 8'h09, 4'hF, 32'h0);
    tl_i.d_ready = 1'b0;
    @(negedge clk);
    tl_i.a_valid = 1'b0;
    check("bp_re", 64'(re_o), 64'd1);
    @(negedge clk);
    drive_a(PUT_FULL_DATA, 32'h48, 2'd2, 8'h0C, 4'hF, 32'h0000_0055);
    rdata_i = 32'h1111_2222;
    for (int i = 0; i < 5; i++) begin
      check("bp_dvalid", 64'(tl_o.d_valid), 64'd1);
      check("bp_ddata", 64'(tl_o.d_data), 64'hCAFE_F00D);
      check("bp_dsource", 64'(tl_o.d_source), 64'h09);
      check("bp_dopcode", 64'(tl_o.d_opcode), 64'(ACCESS_ACK_DATA));
      check("bp_a_ready", 64'(tl_o.a_ready), 64'd0);
      check("bp_strobes", 64'({re_o, we_o}), 64'd0);
      @(negedge clk);
    end
    tl_i.d_ready = 1'b1;
    @(negedge clk);
    check("bp_release_dvalid", 64'(tl_o.d_valid), 64'd0);
    check("bp_release_a_ready", 64'(tl_o.a_ready), 64'd1);
    @(negedge clk);
    tl_i.a_valid = 1'b0;
    check("bp_second_we", 64'(we_o), 64'd1);
    check("bp_second_addr", 64'(addr_o), 64'h48);
    check("bp_second_wdata", 64'(wdata_o), 64'h55);
    @(negedge clk);
    check("bp_second_dvalid", 64'(tl_o.d_valid), 64'd1);
    check("bp_second_dopcode", 64'(tl_o.d_opcode), 64'(ACCESS_ACK));
    @(negedge clk);
    check("bp_second_done", 64'(tl_o.d_valid), 64'd0);

    // Reset asserted during the ACCESS cycle drops the transaction.
    @(negedge clk);
    drive_a(GET, 32'h50, 2'd2, 8'h0D, 4'hF, 32'h0);
    @(negedge clk);
    tl_i.a_valid = 1'b0;
    check("rstmid_re", 64'(re_o), 64'd1);
    rst_i = 1'b1;
    #1;
    check("rstmid_strobes", 64'({re_o, we_o}), 64'd0);
    check("rstmid_a_ready", 64'(tl_o.a_ready), 64'd1);
    check("rstmid_addr", 64'(addr_o), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstmid_no_resp", 64'(tl_o.d_valid), 64'd0);
      check("rstmid_no_strobe", 64'({re_o, we_o}), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
